// File: rtl/ho_select_ctrl.sv
// Handover controller: picks the strongest base station, confirms it over
// several measurement sets with a hysteresis margin, then runs a
// request/respond handshake with a timeout before switching the serving BS.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_SERVE | steady state, serving BS fixed, watching for a better candidate
// S_TTT   | candidate found, counting consecutive confirming samples
// S_REQ   | single cycle, ho_req asserted towards the candidate
// S_WAIT  | waiting for the candidate's respond, timeout counting down
module ho_select_ctrl #(
  parameter int N_BS        = 3,
  parameter int SQ_W        = 8,
  parameter int DATA_W      = 4,
  parameter int HYST        = 8,
  parameter int TTT_N       = 3,
  parameter int RSP_TIMEOUT = 16,
  localparam int ID_W       = $clog2(N_BS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BS*SQ_W-1:0]     sq,
  input  logic                     sq_valid,
  input  logic [N_BS*DATA_W-1:0]   bs_data,
  input  logic [N_BS-1:0]          bs_respond,
  output logic [DATA_W-1:0]        md_data,
  output logic [ID_W-1:0]          serving,
  output logic [N_BS-1:0]          ho_req,
  output logic [ID_W-1:0]          ho_target,
  output logic                     ho_busy,
  output logic                     ho_done,
  output logic                     ho_fail,
  output logic [15:0]              ho_count
);

  localparam int CNT_W = $clog2(TTT_N + 1);
  localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);
  // Margin widened by one bit so serving + HYST never wraps.
  localparam logic [SQ_W:0] HYST_EXT = (SQ_W+1)'(HYST);

  typedef enum logic [1:0] {S_SERVE, S_TTT, S_REQ, S_WAIT} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    cand, cand_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [TMO_W-1:0]   tmo, tmo_nxt;
  logic [ID_W-1:0]    serving_nxt;
  logic [N_BS-1:0]    req_nxt;
  logic               done_nxt, fail_nxt;
  logic [15:0]        count_nxt;

  logic [ID_W-1:0]    best_id;
  logic [SQ_W-1:0]    best_sq, serv_sq;
  logic [DATA_W-1:0]  serv_data;
  logic               resp_cand;
  logic               qualify;

  // Strongest BS (lowest index on ties) plus per-index lookups of the
  // serving BS quality/data and the candidate's respond line.
  always_comb begin
    best_id   = '0;
    best_sq   = sq[0 +: SQ_W];
    serv_sq   = sq[0 +: SQ_W];
    serv_data = bs_data[0 +: DATA_W];
    resp_cand = 1'b0;
    for (int i = 0; i < N_BS; i++) begin
      if (sq[i*SQ_W +: SQ_W] > best_sq) begin
        best_sq = sq[i*SQ_W +: SQ_W];
        best_id = ID_W'(i);
      end
      if (serving == ID_W'(i)) begin
        serv_sq   = sq[i*SQ_W +: SQ_W];
        serv_data = bs_data[i*DATA_W +: DATA_W];
      end
      if (cand == ID_W'(i)) begin
        resp_cand = bs_respond[i];
      end
    end
  end

  assign qualify = (best_id != serving) &&
                   ({1'b0, best_sq} >= ({1'b0, serv_sq} + HYST_EXT));

  // Next-state, counters and registered-output precompute.
  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    cnt_nxt     = cnt;
    tmo_nxt     = tmo;
    serving_nxt = serving;
    done_nxt    = 1'b0;
    fail_nxt    = 1'b0;
    count_nxt   = ho_count;
    req_nxt     = '0;

    case (state)
      S_SERVE: begin
        if (sq_valid && qualify) begin
          cand_nxt  = best_id;
          cnt_nxt   = CNT_W'(1);
          state_nxt = (TTT_N == 1) ? S_REQ : S_TTT;
        end
      end
      S_TTT: begin
        if (sq_valid) begin
          if (qualify && (best_id == cand)) begin
            if ((cnt + CNT_W'(1)) == CNT_W'(TTT_N)) begin
              state_nxt = S_REQ;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            // A different best BS aborts; it must qualify again from SERVE.
            state_nxt = S_SERVE;
            cnt_nxt   = '0;
          end
        end
      end
      S_REQ: begin
        tmo_nxt   = TMO_W'(RSP_TIMEOUT);
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Respond is checked first so it wins in the last WAIT cycle.
        if (resp_cand) begin
          serving_nxt = cand;
          done_nxt    = 1'b1;
          if (ho_count != 16'hFFFF) begin
            count_nxt = ho_count + 16'd1;
          end
          tmo_nxt   = '0;
          state_nxt = S_SERVE;
        end else if (tmo == TMO_W'(1)) begin
          fail_nxt  = 1'b1;
          tmo_nxt   = '0;
          state_nxt = S_SERVE;
        end else begin
          tmo_nxt = tmo - TMO_W'(1);
        end
      end
      default: begin
        state_nxt = S_SERVE;
      end
    endcase

    // ho_req is registered, so it is set on the edge entering REQ.
    if (state_nxt == S_REQ) begin
      for (int i = 0; i < N_BS; i++) begin
        req_nxt[i] = (cand_nxt == ID_W'(i));
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_SERVE;
      cand     <= '0;
      cnt      <= '0;
      tmo      <= '0;
      serving  <= '0;
      md_data  <= '0;
      ho_req   <= '0;
      ho_done  <= 1'b0;
      ho_fail  <= 1'b0;
      ho_count <= '0;
    end else begin
      state    <= state_nxt;
      cand     <= cand_nxt;
      cnt      <= cnt_nxt;
      tmo      <= tmo_nxt;
      serving  <= serving_nxt;
      md_data  <= serv_data;
      ho_req   <= req_nxt;
      ho_done  <= done_nxt;
      ho_fail  <= fail_nxt;
      ho_count <= count_nxt;
    end
  end

  assign ho_busy   = (state != S_SERVE);
  assign ho_target = ho_busy ? cand : serving;

endmodule

// File: tb/tb_ho_select_ctrl.sv
// Bench for ho_select_ctrl: explicit vector table, hand-written corner
// sequences and a randomized run, all shadowed by a behavioural model.
module tb_ho_select_ctrl;

  localparam int N_BS        = 3;
  localparam int SQ_W        = 8;
  localparam int DATA_W      = 4;
  localparam int HYST        = 8;
  localparam int TTT_N       = 3;
  localparam int RSP_TIMEOUT = 16;
  localparam logic [11:0] DAT = 12'hCBA;   // BS0=A, BS1=B, BS2=C

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] sq;
  logic        sq_valid;
  logic [11:0] bs_data;
  logic [2:0]  bs_respond;
  logic [3:0]  md_data;
  logic [1:0]  serving;
  logic [2:0]  ho_req;
  logic [1:0]  ho_target;
  logic        ho_busy;
  logic        ho_done;
  logic        ho_fail;
  logic [15:0] ho_count;

  ho_select_ctrl #(
    .N_BS(N_BS), .SQ_W(SQ_W), .DATA_W(DATA_W), .HYST(HYST),
    .TTT_N(TTT_N), .RSP_TIMEOUT(RSP_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .sq(sq), .sq_valid(sq_valid),
    .bs_data(bs_data), .bs_respond(bs_respond), .md_data(md_data),
    .serving(serving), .ho_req(ho_req), .ho_target(ho_target),
    .ho_busy(ho_busy), .ho_done(ho_done), .ho_fail(ho_fail),
    .ho_count(ho_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: candidate index (-1 none), confirmed samples, handshake age
  // (-1 none, 0 request cycle, k = k-th cycle waiting for respond).
  int m_serving, m_cand, m_conf, m_age, m_md, m_done, m_fail, m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sq_of(input logic [23:0] v, input int i);
    return int'(v[i*8 +: 8]);
  endfunction

  function automatic int dat_of(input logic [11:0] v, input int i);
    return int'(v[i*4 +: 4]);
  endfunction

  function automatic logic [23:0] pk(input int s2, input int s1, input int s0);
    return {8'(s2), 8'(s1), 8'(s0)};
  endfunction

  task automatic model_step(input logic rst, input logic v, input logic [23:0] sqv,
                            input logic [11:0] dat, input logic [2:0] rsp);
    int best;
    bit qual;
    if (rst) begin
      m_serving = 0; m_cand = -1; m_conf = 0; m_age = -1;
      m_md = 0; m_done = 0; m_fail = 0; m_count = 0;
      return;
    end
    m_md   = dat_of(dat, m_serving);
    m_done = 0;
    m_fail = 0;
    if (m_age == 0) begin
      m_age = 1;
    end else if (m_age > 0) begin
      if (rsp[m_cand]) begin
        m_serving = m_cand;
        m_done    = 1;
        if (m_count < 65535) m_count++;
        m_cand = -1; m_conf = 0; m_age = -1;
      end else if (m_age == RSP_TIMEOUT) begin
        m_fail = 1;
        m_cand = -1; m_conf = 0; m_age = -1;
      end else begin
        m_age++;
      end
    end else if (v) begin
      best = 0;
      for (int i = 1; i < N_BS; i++)
        if (sq_of(sqv, i) > sq_of(sqv, best)) best = i;
      qual = (best != m_serving) && (sq_of(sqv, best) >= sq_of(sqv, m_serving) + HYST);
      if (m_cand < 0) begin
        if (qual) begin
          m_cand = best;
          m_conf = 1;
          if (m_conf == TTT_N) m_age = 0;
        end
      end else if (qual && best == m_cand) begin
        m_conf++;
        if (m_conf == TTT_N) m_age = 0;
      end else begin
        m_cand = -1;
        m_conf = 0;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, compare after.
  task automatic cycle(input logic rst, input logic v, input logic [23:0] sqv,
                       input logic [11:0] dat, input logic [2:0] rsp);
    reset = rst; sq_valid = v; sq = sqv; bs_data = dat; bs_respond = rsp;
    @(posedge clk);
    model_step(rst, v, sqv, dat, rsp);
    #1;
    chk("m_serving", serving, m_serving);
    chk("m_md_data", md_data, m_md);
    chk("m_ho_req", ho_req, (m_age == 0) ? (1 << m_cand) : 0);
    chk("m_ho_busy", ho_busy, (m_cand >= 0) ? 1 : 0);
    chk("m_ho_target", ho_target, (m_cand >= 0) ? m_cand : m_serving);
    chk("m_ho_done", ho_done, m_done);
    chk("m_ho_fail", ho_fail, m_fail);
    chk("m_ho_count", ho_count, m_count);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, pk(0, 0, 0), DAT, 3'b000);
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [23:0] sqv;
    logic [2:0]  rsp;
    int          e_serving;
    int          e_req;
    int          e_busy;
    int          e_done;
    int          e_md;
    int          e_count;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int fail_at;
    logic [23:0] rsq;
    logic [2:0]  rrsp;

    //          rst v  sq                 rsp     srv req busy done md cnt
    tbl[0]  = '{1'b1, 1'b0, pk(10, 10, 10), 3'b000, 0, 0, 0, 0, 0,  0};
    tbl[1]  = '{1'b0, 1'b1, pk(10, 10, 10), 3'b000, 0, 0, 0, 0, 10, 0};
    tbl[2]  = '{1'b0, 1'b1, pk(40, 0, 30),  3'b000, 0, 0, 1, 0, 10, 0};
    tbl[3]  = '{1'b0, 1'b0, pk(40, 0, 30),  3'b000, 0, 0, 1, 0, 10, 0};
    tbl[4]  = '{1'b0, 1'b1, pk(40, 0, 30),  3'b000, 0, 0, 1, 0, 10, 0};
    tbl[5]  = '{1'b0, 1'b1, pk(40, 0, 30),  3'b000, 0, 4, 1, 0, 10, 0};
    tbl[6]  = '{1'b0, 1'b0, pk(40, 0, 30),  3'b000, 0, 0, 1, 0, 10, 0};
    tbl[7]  = '{1'b0, 1'b0, pk(40, 0, 30),  3'b100, 2, 0, 0, 1, 10, 1};
    tbl[8]  = '{1'b0, 1'b0, pk(40, 0, 30),  3'b000, 2, 0, 0, 0, 12, 1};
    tbl[9]  = '{1'b0, 1'b1, pk(30, 0, 37),  3'b000, 2, 0, 0, 0, 12, 1};
    tbl[10] = '{1'b0, 1'b1, pk(30, 0, 37),  3'b000, 2, 0, 0, 0, 12, 1};
    tbl[11] = '{1'b0, 1'b1, pk(30, 0, 38),  3'b000, 2, 0, 1, 0, 12, 1};
    tbl[12] = '{1'b0, 1'b1, pk(30, 0, 37),  3'b000, 2, 0, 0, 0, 12, 1};

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].sqv, DAT, tbl[i].rsp);
      chk("tbl_serving", serving, tbl[i].e_serving);
      chk("tbl_ho_req", ho_req, tbl[i].e_req);
      chk("tbl_ho_busy", ho_busy, tbl[i].e_busy);
      chk("tbl_ho_done", ho_done, tbl[i].e_done);
      chk("tbl_md_data", md_data, tbl[i].e_md);
      chk("tbl_ho_count", ho_count, tbl[i].e_count);
    end

    // Candidate BS1 twice, then BS2 best: abort, no request.
    do_reset();
    cycle(1'b0, 1'b1, pk(0, 50, 10), DAT, 3'b000);
    chk("sw_target", ho_target, 1);
    cycle(1'b0, 1'b1, pk(0, 50, 10), DAT, 3'b000);
    chk("sw_busy2", ho_busy, 1);
    cycle(1'b0, 1'b1, pk(60, 50, 10), DAT, 3'b000);
    chk("sw_busy3", ho_busy, 0);
    chk("sw_req3", ho_req, 0);
    cycle(1'b0, 1'b0, pk(60, 50, 10), DAT, 3'b000);
    chk("sw_req4", ho_req, 0);

    // Timeout with respond only on non-candidate BSs.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, pk(0, 50, 10), DAT, 3'b000);
    chk("to_req", ho_req, 3'b010);
    fail_at = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b0, 1'b0, pk(0, 50, 10), DAT, 3'b101);
      if (ho_fail) begin
        fail_at = k;
        break;
      end
    end
    chk("to_fail_delay", fail_at, RSP_TIMEOUT + 1);
    chk("to_serving", serving, 0);
    chk("to_done", ho_done, 0);
    chk("to_count", ho_count, 0);

    // Respond in the last WAIT cycle wins over timeout.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, pk(0, 50, 10), DAT, 3'b000);
    chk("last_req", ho_req, 3'b010);
    for (int k = 1; k <= RSP_TIMEOUT; k++) cycle(1'b0, 1'b0, pk(0, 50, 10), DAT, 3'b000);
    cycle(1'b0, 1'b0, pk(0, 50, 10), DAT, 3'b010);
    chk("last_done", ho_done, 1);
    chk("last_fail", ho_fail, 0);
    chk("last_serving", serving, 1);
    cycle(1'b0, 1'b0, pk(0, 50, 10), DAT, 3'b000);
    chk("last_fail_after", ho_fail, 0);
    chk("last_md", md_data, 11);

    // Reset while waiting for respond (serving 1, count 1 beforehand).
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, pk(0, 10, 60), DAT, 3'b000);
    chk("rw_req", ho_req, 3'b001);
    cycle(1'b0, 1'b0, pk(0, 10, 60), DAT, 3'b000);
    chk("rw_busy", ho_busy, 1);
    cycle(1'b1, 1'b0, pk(0, 10, 60), DAT, 3'b111);
    chk("rw_serving", serving, 0);
    chk("rw_md", md_data, 0);
    chk("rw_busy0", ho_busy, 0);
    chk("rw_target", ho_target, 0);
    chk("rw_count", ho_count, 0);
    chk("rw_req0", ho_req, 0);
    cycle(1'b0, 1'b0, pk(0, 10, 60), DAT, 3'b111);
    chk("rw_done", ho_done, 0);
    chk("rw_fail", ho_fail, 0);

    // Tie between BS1 and BS2 picks the lower index.
    do_reset();
    cycle(1'b0, 1'b1, pk(90, 90, 50), DAT, 3'b000);
    chk("tie_target", ho_target, 1);
    chk("tie_busy", ho_busy, 1);

    // Margin one short of HYST, and serving near the top of the range.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, pk(37, 0, 30), DAT, 3'b000);
      chk("hyst7_busy", ho_busy, 0);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, pk(0, 255, 250), DAT, 3'b000);
      chk("top_busy", ho_busy, 0);
    end

    // Randomized run against the model.
    do_reset();
    rsq = pk(100, 100, 100);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0)
        rsq = pk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      for (int b = 0; b < N_BS; b++) rrsp[b] = ($urandom_range(0, 11) == 0);
      cycle(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), rsq,
            12'($urandom), rrsp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
